ifu_fetch: RTL and testbench

- Instruction fetch unit; the producer side of the decode interface.
- Holds the PC and issues one word-aligned request at a time to instruction memory over a valid/ready request/response channel.
- Presents the fetched word, its PC and the pre-split decode fields (opcode, funct3, funct7 bit) to the control/decode stage with a valid/ready handshake.
- Accepts a redirect (branch/jump target) from execute and squashes any stale fetch.

---
 rtl/ifu_fetch_pkg.sv | 27 ++
 rtl/ifu_fetch_pc_gen.sv | 45 ++++
 rtl/ifu_fetch.sv | 160 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC, decode field positions, FSM states.
// IFU_ZERO_HALT_EN adds the HALT state used when an all-zero instruction word is fetched.
package ifu_fetch_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int unsigned INST_W       = 32;
  localparam int unsigned PC_STEP      = 4;

  localparam int unsigned OPCODE_MSB = 6;
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned FUNCT3_MSB = 14;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT7_BIT = 30;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
`ifdef IFU_ZERO_HALT_EN
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
`else
    ST_HOLD = 2'd2
`endif
  } fetch_state_t;

endpackage

// File: rtl/ifu_fetch_pc_gen.sv
// PC register and in-flight PC capture for the fetch unit.
// Next-PC priority: redirect target, then sequential increment, then hold.
module ifu_pc_gen
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_load,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            incr,
  input  logic            capture,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_inflight
);

  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] align_mask;

  assign align_mask = ~XLEN'(2'b11);

  always_comb begin
    pc_next = pc;
    if (redirect_load) begin
      pc_next = redirect_pc & align_mask;
    end else if (incr) begin
      pc_next = pc + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC & align_mask;
      pc_inflight <= '0;
    end else begin
      pc <= pc_next;
      if (capture) begin
        pc_inflight <= pc;
      end
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, redirect squashing, decode-side handshake.
// Build option IFU_ZERO_HALT_EN: an all-zero fetched word halts fetch instead of being delivered.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  output logic              imem_rsp_ready,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic [6:0]        opcode,
  output logic [2:0]        funct3,
  output logic              funct7,
  output logic              halted
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic            drop;
  logic            pc_redirect;
  logic            pc_incr;
  logic            pc_capture;
  logic            inst_load;
  logic            drop_set;
  logic            drop_clr;
  logic            req_fire;
  logic            rsp_fire;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_inflight;

  ifu_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_load (pc_redirect),
    .redirect_pc   (redirect_pc),
    .incr          (pc_incr),
    .capture       (pc_capture),
    .pc            (pc),
    .pc_inflight   (pc_inflight)
  );

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_fire = imem_rsp_valid & imem_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_REQ;
    end else begin
      state <= state_next;
    end
  end

  // drop marks the single outstanding request as stale after a redirect in WAIT
  always_comb begin
    state_next  = state;
    pc_redirect = 1'b0;
    pc_incr     = 1'b0;
    pc_capture  = 1'b0;
    inst_load   = 1'b0;
    drop_set    = 1'b0;
    drop_clr    = 1'b0;
    unique case (state)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_redirect = 1'b1;
        end else if (req_fire) begin
          pc_capture = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        pc_redirect = redirect_valid;
        if (rsp_fire) begin
          if (drop) begin
            drop_clr   = 1'b1;
            state_next = ST_REQ;
          end else if (redirect_valid) begin
            state_next = ST_REQ;
`ifdef IFU_ZERO_HALT_EN
          end else if (imem_rsp_data == '0) begin
            state_next = ST_HALT;
`endif
          end else begin
            inst_load  = 1'b1;
            pc_incr    = 1'b1;
            state_next = ST_HOLD;
          end
        end else if (redirect_valid) begin
          drop_set = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_redirect = 1'b1;
          state_next  = ST_REQ;
        end else if (inst_ready) begin
          state_next = ST_REQ;
        end
      end
`ifdef IFU_ZERO_HALT_EN
      ST_HALT: begin
        state_next = ST_HALT;
      end
`endif
      default: begin
        state_next = ST_REQ;
      end
    endcase
  end

  always_comb begin
    imem_req_valid = rst_n && (state == ST_REQ) && !redirect_valid;
    imem_req_addr  = pc;
    imem_rsp_ready = (state == ST_WAIT);
    inst_valid     = (state == ST_HOLD);
`ifdef IFU_ZERO_HALT_EN
    halted         = (state == ST_HALT);
`else
    halted         = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop    <= 1'b0;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      if (drop_set) begin
        drop <= 1'b1;
      end else if (drop_clr) begin
        drop <= 1'b0;
      end
      if (inst_load) begin
        inst    <= imem_rsp_data;
        inst_pc <= pc_inflight;
      end
    end
  end

  assign opcode = inst[OPCODE_MSB:OPCODE_LSB];
  assign funct3 = inst[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7 = inst[FUNCT7_BIT];

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: gated zero/long-latency memory model and delivery scoreboard.
// Build with IFU_ZERO_HALT_EN defined to exercise the halt-on-zero variant.
module tb_ifu_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } dlv_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7;
  logic        halted;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  logic [31:0] exp_addr[$];
  dlv_t        exp_dlv[$];

  int unsigned req_grant = 0;
  int unsigned req_count = 0;
  int unsigned dlv_count = 0;
  int unsigned mem_lat   = 1;
  bit          zero_mode = 1'b0;
  int unsigned cyc       = 0;
  int unsigned last_dlv  = 0;
  int unsigned dlv_gap   = 0;

  ifu_fetch #(
    .XLEN     (32),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // addi-shaped word carrying the word index in its immediate; zero_mode returns 0
  function automatic logic [31:0] mem_word(input logic [31:0] a, input bit zero);
    if (zero) return 32'h0;
    return {a[13:2], 20'h00013};
  endfunction

  function automatic dlv_t mk_dlv(input logic [31:0] pc, input bit zero);
    dlv_t d;
    d.pc   = pc;
    d.word = mem_word(pc, zero);
    return d;
  endfunction

  // memory model and scoreboard: drive at negedge+1, sample at negedge+2
  initial begin : mem_model
    bit          pend = 1'b0;
    int unsigned cnt  = 0;
    logic [31:0] rsp_addr = '0;
    dlv_t        d;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        pend           = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
      end else begin
        imem_req_ready = (req_count < req_grant);
        if (pend && cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(rsp_addr, zero_mode);
        end else begin
          imem_rsp_valid = 1'b0;
          if (pend) cnt--;
        end
      end
      #1;
      if (imem_rsp_valid && imem_rsp_ready) pend = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        req_count++;
        check("req_expected", 64'(exp_addr.size() > 0), 64'd1);
        if (exp_addr.size() > 0) check("req_addr", 64'(imem_req_addr), 64'(exp_addr.pop_front()));
        pend     = 1'b1;
        rsp_addr = imem_req_addr;
        cnt      = mem_lat - 1;
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        dlv_count++;
        dlv_gap  = cyc - last_dlv;
        last_dlv = cyc;
        check("dlv_expected", 64'(exp_dlv.size() > 0), 64'd1);
        if (exp_dlv.size() > 0) begin
          d = exp_dlv.pop_front();
          check("dlv_inst", 64'(inst), 64'(d.word));
          check("dlv_pc", 64'(inst_pc), 64'(d.pc));
        end
      end
    end
  end

  task automatic wait_dlv(input int unsigned n);
    for (int i = 0; i < 100 && dlv_count < n; i++) @(negedge clk);
    check("wait_dlv", 64'(dlv_count >= n), 64'd1);
  endtask

  task automatic wait_req(input int unsigned n);
    for (int i = 0; i < 100 && req_count < n; i++) @(negedge clk);
    check("wait_req", 64'(req_count >= n), 64'd1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100 && !inst_valid; i++) @(negedge clk);
    check("wait_valid", 64'(inst_valid), 64'd1);
  endtask

  initial begin : global_timeout
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    dlv_t        d;
    int unsigned d0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_inst_pc", 64'(inst_pc), 64'd0);
    check("rst_addr", 64'(imem_req_addr), 64'h8000_0000);

    // sequential fetch, zero-wait memory
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back(32'h8000_0000 + 32'(4 * i));
      exp_dlv.push_back(mk_dlv(32'h8000_0000 + 32'(4 * i), 1'b0));
    end
    inst_ready = 1'b1;
    req_grant  = 3;
    rst_n      = 1'b1;
    wait_dlv(2);
    check("cadence_1", 64'(dlv_gap), 64'd3);
    wait_dlv(3);
    check("cadence_2", 64'(dlv_gap), 64'd3);

    // decode stall in HOLD
    inst_ready = 1'b0;
    d = mk_dlv(32'h8000_000C, 1'b0);
    exp_addr.push_back(32'h8000_000C);
    exp_dlv.push_back(d);
    req_grant = 4;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("hold_inst", 64'(inst), 64'(d.word));
      check("hold_pc", 64'(inst_pc), 64'(d.pc));
      check("hold_opcode", 64'(opcode), 64'(d.word[6:0]));
      check("hold_funct3", 64'(funct3), 64'(d.word[14:12]));
      check("hold_funct7", 64'(funct7), 64'(d.word[30]));
      check("hold_no_req", 64'(imem_req_valid), 64'd0);
      @(negedge clk);
    end
    inst_ready = 1'b1;
    wait_dlv(4);

    // redirect while waiting on a slow response
    mem_lat = 3;
    exp_addr.push_back(32'h8000_0010);
    req_grant = 5;
    wait_req(5);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    mem_lat        = 1;
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_addr.push_back(32'h8000_0100);
    exp_dlv.push_back(mk_dlv(32'h8000_0100, 1'b0));
    req_grant = 6;
    for (int i = 0; i < 10 && req_count < 6; i++) begin
      check("stale_no_valid", 64'(inst_valid), 64'd0);
      @(negedge clk);
    end
    wait_dlv(5);

    // redirect in HOLD with decode ready in the same cycle
    inst_ready = 1'b0;
    exp_addr.push_back(32'h8000_0104);
    req_grant = 7;
    wait_valid();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0203;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("squash_valid", 64'(inst_valid), 64'd0);
    check("squash_addr", 64'(imem_req_addr), 64'h8000_0200);
    exp_addr.push_back(32'h8000_0200);
    exp_dlv.push_back(mk_dlv(32'h8000_0200, 1'b0));
    req_grant = 8;
    wait_dlv(6);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0000_0000);
    exp_dlv.push_back(mk_dlv(32'hFFFF_FFFC, 1'b0));
    exp_dlv.push_back(mk_dlv(32'h0000_0000, 1'b0));
    req_grant = 10;
    wait_dlv(8);

    // all-zero instruction word
    zero_mode = 1'b1;
    exp_addr.push_back(32'h0000_0004);
`ifdef IFU_ZERO_HALT_EN
    req_grant = 11;
    wait_req(11);
    repeat (4) @(negedge clk);
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_inst_valid", 64'(inst_valid), 64'd0);
    req_grant      = 12;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0000;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("halt_no_req", 64'(imem_req_valid), 64'd0);
      check("halt_sticky", 64'(halted), 64'd1);
      @(negedge clk);
    end
    check("halt_req_count", 64'(req_count), 64'd11);
`else
    exp_dlv.push_back(mk_dlv(32'h0000_0004, 1'b1));
    req_grant = 11;
    wait_dlv(9);
    check("zero_halted", 64'(halted), 64'd0);
    repeat (2) @(negedge clk);
    check("zero_still_fetching", 64'(imem_req_valid), 64'd1);
`endif

    // reset while fetch is active or halted
    zero_mode = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    check("rst2_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst2_halted", 64'(halted), 64'd0);
    check("rst2_inst_valid", 64'(inst_valid), 64'd0);
    d0 = dlv_count;
    exp_addr.push_back(32'h8000_0000);
    exp_dlv.push_back(mk_dlv(32'h8000_0000, 1'b0));
    req_grant = req_count + 1;
    rst_n     = 1'b1;
    wait_dlv(d0 + 1);

    repeat (3) @(negedge clk);
    check("addr_q_empty", 64'(exp_addr.size()), 64'd0);
    check("dlv_q_empty", 64'(exp_dlv.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
